// File: rtl/led_override_mux_if.sv
// Signal bundle between the housekeeping/sequencer side and the LED output
// stage. The master modport is whoever drives the requests (the sequencer
// and housekeeping registers). The slave modport is the output stage itself.
interface led_override_mux_if #(
    parameter int PWM_BITS = 4
);
    logic [7:0]          hk_led_i;
    logic [PWM_BITS-1:0] hk_dim_i;
    logic                ovr_drive_i;
    logic [7:0]          ovr_data_i;
    logic                ovr_enable_i;
    logic                cnt_clr_i;
    logic [7:0]          led_o;
    logic                ovr_active_o;
    logic [7:0]          ovr_count_o;

    modport master (
        output hk_led_i,
        output hk_dim_i,
        output ovr_drive_i,
        output ovr_data_i,
        output ovr_enable_i,
        output cnt_clr_i,
        input  led_o,
        input  ovr_active_o,
        input  ovr_count_o
    );

    modport slave (
        input  hk_led_i,
        input  hk_dim_i,
        input  ovr_drive_i,
        input  ovr_data_i,
        input  ovr_enable_i,
        input  cnt_clr_i,
        output led_o,
        output ovr_active_o,
        output ovr_count_o
    );
endinterface

// File: rtl/led_override_mux.sv
// LED output stage. It shows the PWM-dimmed housekeeping pattern in normal
// operation. An enabled override request from the sequencer takes over the
// LEDs at full brightness. After the request drops, the last override pattern
// stays visible for HOLD_CYCLES. Override episodes are counted for software.
// Every output is registered.
module led_override_mux #(
    parameter int unsigned HOLD_CYCLES = 125_000_000,
    parameter int          HOLD_W      = 27,
    parameter int          PWM_BITS    = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    led_override_mux_if.slave        bus
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ALERT  = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Reload value for the hold counter. The counter runs down to zero, so
    // HOLD_CYCLES-1 plus the entry cycle gives exactly HOLD_CYCLES cycles.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [PWM_BITS-1:0] pwm_ctr;
    logic [HOLD_W-1:0]   hold_ctr;
    logic [HOLD_W-1:0]   hold_next;
    logic [7:0]          last_ovr;
    logic [7:0]          last_next;
    logic [7:0]          led_reg;
    logic [7:0]          led_next;
    logic                active_reg;
    logic [7:0]          count_reg;
    logic [7:0]          count_next;
    logic                count_inc;
    logic [7:0]          normal_led;

    // Dimmed housekeeping pattern. It is lit while the free-running counter
    // (before its increment) is at or below the brightness setting.
    always_comb begin
        normal_led = 8'h00;
        if (pwm_ctr <= bus.hk_dim_i) begin
            normal_led = bus.hk_led_i;
        end
    end

    // Next state, next LED value and override bookkeeping, evaluated in priority order
    always_comb begin
        state_next = state;
        led_next   = normal_led;
        last_next  = last_ovr;
        hold_next  = hold_ctr;
        count_inc  = 1'b0;

        case (state)
            NORMAL: begin
                if (bus.ovr_drive_i && bus.ovr_enable_i) begin
                    state_next = ALERT;
                    led_next   = bus.ovr_data_i;
                    last_next  = bus.ovr_data_i;
                    count_inc  = 1'b1;
                end
            end

            ALERT: begin
                if (!bus.ovr_enable_i) begin
                    state_next = NORMAL;
                end else if (bus.ovr_drive_i) begin
                    led_next  = bus.ovr_data_i;
                    last_next = bus.ovr_data_i;
                end else begin
                    state_next = HOLD;
                    hold_next  = HOLD_LOAD;
                    led_next   = last_ovr;
                end
            end

            HOLD: begin
                if (!bus.ovr_enable_i) begin
                    state_next = NORMAL;
                end else if (bus.ovr_drive_i) begin
                    state_next = ALERT;
                    led_next   = bus.ovr_data_i;
                    last_next  = bus.ovr_data_i;
                end else if (hold_ctr == '0) begin
                    state_next = NORMAL;
                end else begin
                    hold_next = hold_ctr - 1'b1;
                    led_next  = last_ovr;
                end
            end

            default: begin
                state_next = NORMAL;
            end
        endcase
    end

    // Episode counter. It saturates at all-ones. A clear that coincides with a
    // new entry still counts that entry.
    always_comb begin
        count_next = count_reg;
        if (bus.cnt_clr_i) begin
            count_next = count_inc ? 8'd1 : 8'd0;
        end else if (count_inc && (count_reg != 8'hFF)) begin
            count_next = count_reg + 8'd1;
        end
    end

    // State register and all output registers, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= NORMAL;
            pwm_ctr    <= '0;
            hold_ctr   <= '0;
            last_ovr   <= 8'h00;
            led_reg    <= 8'h00;
            active_reg <= 1'b0;
            count_reg  <= 8'h00;
        end else begin
            state      <= state_next;
            pwm_ctr    <= pwm_ctr + 1'b1;
            hold_ctr   <= hold_next;
            last_ovr   <= last_next;
            led_reg    <= led_next;
            active_reg <= (state_next != NORMAL);
            count_reg  <= count_next;
        end
    end

    assign bus.led_o        = led_reg;
    assign bus.ovr_active_o = active_reg;
    assign bus.ovr_count_o  = count_reg;

endmodule

// File: tb/tb_led_override_mux.sv
// Self-checking bench for led_override_mux. It uses directed scenarios plus a
// randomized run. The reference model tracks override episodes by timestamps
// and plain arithmetic.
module tb_led_override_mux;

    localparam int HOLD     = 4;
    localparam int PWM_BITS = 4;
    localparam int PWM_LEN  = 1 << PWM_BITS;

    logic clk;
    logic resetn;

    led_override_mux_if #(.PWM_BITS(PWM_BITS)) bus ();

    led_override_mux #(
        .HOLD_CYCLES (HOLD),
        .HOLD_W      (8),
        .PWM_BITS    (PWM_BITS)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nChecks   = 0;
    int nFailures = 0;

    // Reference model state
    int mPwm      = 0;
    int mEdge     = 0;
    int mDropEdge = 0;
    bit mActive   = 0;
    bit mHolding  = 0;
    int mLast     = 0;
    int mCount    = 0;
    int mLed      = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        if (observed !== expected) begin
            nFailures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock edge of the intended behaviour, computed from the sampled inputs
    task automatic modelStep();
        int normalLed;
        bit inc;
        if (!resetn) begin
            mPwm = 0; mActive = 0; mHolding = 0; mLast = 0; mCount = 0; mLed = 0;
            mEdge++;
            return;
        end
        normalLed = (mPwm <= int'(bus.hk_dim_i)) ? int'(bus.hk_led_i) : 0;
        inc = 0;
        if (!bus.ovr_enable_i) begin
            mActive = 0; mHolding = 0; mLed = normalLed;
        end else if (bus.ovr_drive_i) begin
            if (!mActive) inc = 1;
            mActive = 1; mHolding = 0;
            mLed = int'(bus.ovr_data_i);
            mLast = mLed;
        end else if (mActive) begin
            if (!mHolding) begin
                mHolding = 1;
                mDropEdge = mEdge;
            end
            if (mEdge - mDropEdge < HOLD) begin
                mLed = mLast;
            end else begin
                mActive = 0; mHolding = 0; mLed = normalLed;
            end
        end else begin
            mLed = normalLed;
        end
        if (bus.cnt_clr_i) mCount = inc ? 1 : 0;
        else if (inc && mCount < 255) mCount++;
        mPwm = (mPwm + 1) % PWM_LEN;
        mEdge++;
    endtask

    // Drive one cycle of inputs, advance the model, and compare after the edge
    task automatic applyStimulus(input bit rstn, input int hk, input int dim, input bit drive,
                                 input int data, input bit en, input bit clr);
        resetn           = rstn;
        bus.hk_led_i     = 8'(hk);
        bus.hk_dim_i     = PWM_BITS'(dim);
        bus.ovr_drive_i  = drive;
        bus.ovr_data_i   = 8'(data);
        bus.ovr_enable_i = en;
        bus.cnt_clr_i    = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("model_led", int'(bus.led_o), mLed);
        checkOutput("model_active", int'(bus.ovr_active_o), int'(mActive));
        checkOutput("model_count", int'(bus.ovr_count_o), mCount);
    endtask

    initial begin
        bit drv;
        bit enb;
        int dim;
        int hk;

        // Reset: LEDs dark while reset is held
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'hA5, 3, 0, 0, 0, 0);
            checkOutput("reset_led", int'(bus.led_o), 0);
        end

        // PWM at dim=3: four lit cycles out of sixteen, twice around
        for (int i = 0; i < 2 * PWM_LEN; i++) begin
            applyStimulus(1, 8'hA5, 3, 0, 0, 0, 0);
            checkOutput("pwm_pattern", int'(bus.led_o), ((i % PWM_LEN) < 4) ? 8'hA5 : 8'h00);
        end

        // Full brightness at dim=15
        for (int i = 0; i < PWM_LEN; i++) begin
            applyStimulus(1, 8'hA5, 15, 0, 0, 0, 0);
            checkOutput("pwm_full", int'(bus.led_o), 8'hA5);
        end

        // Override entry and data stepping
        applyStimulus(1, 8'hA5, 15, 0, 0, 1, 0);
        applyStimulus(1, 8'hA5, 15, 1, 8'hFF, 1, 0);
        checkOutput("entry_led", int'(bus.led_o), 8'hFF);
        checkOutput("entry_active", int'(bus.ovr_active_o), 1);
        checkOutput("entry_count", int'(bus.ovr_count_o), 1);
        applyStimulus(1, 8'hA5, 15, 1, 8'h05, 1, 0);
        checkOutput("step_05", int'(bus.led_o), 8'h05);
        applyStimulus(1, 8'hA5, 15, 1, 8'h11, 1, 0);
        checkOutput("step_11", int'(bus.led_o), 8'h11);

        // Hold expiry: four cycles of 8'h11, then normal output
        for (int i = 0; i < HOLD; i++) begin
            applyStimulus(1, 8'hA5, 15, 0, 8'h77, 1, 0);
            checkOutput("hold_led", int'(bus.led_o), 8'h11);
            checkOutput("hold_active", int'(bus.ovr_active_o), 1);
        end
        applyStimulus(1, 8'hA5, 15, 0, 8'h77, 1, 0);
        checkOutput("expire_led", int'(bus.led_o), 8'hA5);
        checkOutput("expire_active", int'(bus.ovr_active_o), 0);

        // Re-assert during HOLD keeps the count and restarts a full hold
        applyStimulus(1, 8'hA5, 15, 1, 8'h33, 1, 0);
        checkOutput("second_count", int'(bus.ovr_count_o), 2);
        applyStimulus(1, 8'hA5, 15, 0, 0, 1, 0);
        applyStimulus(1, 8'hA5, 15, 0, 0, 1, 0);
        applyStimulus(1, 8'hA5, 15, 1, 8'h22, 1, 0);
        checkOutput("reassert_led", int'(bus.led_o), 8'h22);
        checkOutput("reassert_count", int'(bus.ovr_count_o), 2);
        for (int i = 0; i < HOLD; i++) begin
            applyStimulus(1, 8'hA5, 15, 0, 0, 1, 0);
            checkOutput("rehold_led", int'(bus.led_o), 8'h22);
        end
        applyStimulus(1, 8'hA5, 15, 0, 0, 1, 0);
        checkOutput("rehold_done", int'(bus.led_o), 8'hA5);

        // Enable gating after a fresh reset
        applyStimulus(0, 8'hA5, 15, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'hA5, 15, 1, 8'h3C, 0, 0);
            checkOutput("gated_count", int'(bus.ovr_count_o), 0);
            checkOutput("gated_active", int'(bus.ovr_active_o), 0);
        end

        // Enable cleared while in HOLD
        applyStimulus(1, 8'hA5, 15, 1, 8'h3C, 1, 0);
        applyStimulus(1, 8'hA5, 15, 0, 0, 1, 0);
        applyStimulus(1, 8'hA5, 15, 0, 0, 0, 0);
        checkOutput("hold_disable_active", int'(bus.ovr_active_o), 0);
        checkOutput("hold_disable_led", int'(bus.led_o), 8'hA5);

        // Reset while in ALERT
        applyStimulus(1, 8'hA5, 15, 1, 8'h3C, 1, 0);
        applyStimulus(0, 8'hA5, 15, 1, 8'h3C, 1, 0);
        checkOutput("alert_reset_led", int'(bus.led_o), 0);
        checkOutput("alert_reset_count", int'(bus.ovr_count_o), 0);
        checkOutput("alert_reset_active", int'(bus.ovr_active_o), 0);

        // Randomized run against the model
        drv = 0; enb = 1; dim = 7; hk = 8'h5A;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5, 0) == 0) drv = ~drv;
            if ($urandom_range(19, 0) == 0) enb = ~enb;
            if ($urandom_range(49, 0) == 0) dim = int'($urandom_range(PWM_LEN - 1, 0));
            if ($urandom_range(19, 0) == 0) hk = int'($urandom_range(255, 0));
            applyStimulus($urandom_range(199, 0) != 0, hk, dim, drv, int'($urandom_range(255, 0)),
                          enb, $urandom_range(29, 0) == 0);
        end

        // Saturation: 260 episodes, then clear coincident with an entry, then clear alone
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1, 8'h0F, 8, 1, i, 1, 0);
            applyStimulus(1, 8'h0F, 8, 0, 0, 0, 0);
        end
        checkOutput("saturated_count", int'(bus.ovr_count_o), 8'hFF);
        applyStimulus(1, 8'h0F, 8, 1, 8'h99, 1, 1);
        checkOutput("clear_with_entry", int'(bus.ovr_count_o), 1);
        applyStimulus(1, 8'h0F, 8, 1, 8'h99, 1, 1);
        checkOutput("clear_alone", int'(bus.ovr_count_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFailures);
        $finish;
    end

endmodule
